// File: rtl/pc_ctrl_pkg.sv
// Shared types and default constants for the PC fetch controller.
package pc_ctrl_pkg;

  localparam int unsigned DEF_WIDTH    = 32;
  localparam logic [31:0] DEF_RESET_PC = 32'h0040_0000;
  localparam int unsigned DEF_STEP     = 4;
  localparam int unsigned DEF_MAX_WAIT = 15;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_ERR  = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    PC_HOLD = 2'd0,
    PC_STEP = 2'd1,
    PC_TGT  = 2'd2
  } pc_sel_e;

endpackage

// File: rtl/pc_fetch_ctrl_if.sv
// Instruction-fetch handshake between the PC controller and instruction memory.
interface pc_fetch_ctrl_if #(
  parameter int unsigned WIDTH = 32
);
  logic             mem_req;
  logic [WIDTH-1:0] mem_addr;
  logic             mem_ack;

  modport master (output mem_req, output mem_addr, input mem_ack);
  modport slave  (input mem_req, input mem_addr, output mem_ack);
endinterface

// File: rtl/pc_reg.sv
// Program-counter register with hold / sequential step / aligned target load.
module pc_reg
  import pc_ctrl_pkg::*;
#(
  parameter int unsigned      WIDTH    = DEF_WIDTH,
  parameter logic [WIDTH-1:0] RESET_PC = WIDTH'(DEF_RESET_PC),
  parameter int unsigned      STEP     = DEF_STEP
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             load_i,
  input  pc_sel_e          sel_i,
  input  logic [WIDTH-1:0] target_i,
  output logic [WIDTH-1:0] pc_o
);

  // Targets are forced onto a STEP boundary.
  localparam logic [WIDTH-1:0] ALIGN_MASK = ~(WIDTH'(STEP - 1));

  logic [WIDTH-1:0] pc_q;
  logic [WIDTH-1:0] pc_d;

  // Next-value mux; the increment wraps silently.
  always_comb begin
    pc_d = pc_q;
    unique case (sel_i)
      PC_HOLD: pc_d = pc_q;
      PC_STEP: pc_d = pc_q + WIDTH'(STEP);
      PC_TGT:  pc_d = target_i & ALIGN_MASK;
      default: pc_d = pc_q;
    endcase
  end

  // PC storage with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pc_q <= RESET_PC;
    end else if (load_i) begin
      pc_q <= pc_d;
    end
  end

  assign pc_o = pc_q;

endmodule

// File: rtl/pc_fetch_ctrl.sv
// PC sequencing controller: one outstanding fetch, branch redirect, timeout trap.
module pc_fetch_ctrl
  import pc_ctrl_pkg::*;
#(
  parameter int unsigned      WIDTH    = DEF_WIDTH,
  parameter logic [WIDTH-1:0] RESET_PC = WIDTH'(DEF_RESET_PC),
  parameter int unsigned      STEP     = DEF_STEP,
  parameter int unsigned      MAX_WAIT = DEF_MAX_WAIT
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               en,
  input  logic               stall,
  input  logic               br_valid,
  input  logic [WIDTH-1:0]   br_target,
  pc_fetch_ctrl_if.master    mem,
  output logic [WIDTH-1:0]   pc_out,
  output logic               inst_valid,
  output logic               timeout_err,
  output logic               busy
);

  localparam int unsigned WAIT_W = $clog2(MAX_WAIT + 1);

  state_e             state_q, state_d;
  logic [WAIT_W-1:0]  wait_q, wait_d;
  logic               br_pend_q, br_pend_d;
  logic [WIDTH-1:0]   br_addr_q, br_addr_d;
  logic               inst_valid_q, inst_valid_d;
  logic               err_q, err_d;
  logic               mem_req_q, mem_req_d;
  logic               busy_q, busy_d;

  logic               pc_load;
  pc_sel_e            pc_sel;
  logic [WIDTH-1:0]   pc_tgt;
  logic [WIDTH-1:0]   pc_q;

  pc_reg #(
    .WIDTH    (WIDTH),
    .RESET_PC (RESET_PC),
    .STEP     (STEP)
  ) u_pc_reg (
    .clk_i    (CLK),
    .rst_i    (RST),
    .load_i   (pc_load),
    .sel_i    (pc_sel),
    .target_i (pc_tgt),
    .pc_o     (pc_q)
  );

  // Next-state, PC update, wait counter and branch latch.
  always_comb begin
    state_d      = state_q;
    wait_d       = wait_q;
    br_pend_d    = br_pend_q;
    br_addr_d    = br_addr_q;
    inst_valid_d = 1'b0;
    err_d        = err_q;
    pc_load      = 1'b0;
    pc_sel       = PC_HOLD;
    pc_tgt       = br_target;

    unique case (state_q)
      S_IDLE: begin
        // Redirect the PC while idle so the next request already uses the target.
        if (br_valid) begin
          pc_load   = 1'b1;
          pc_sel    = PC_TGT;
          pc_tgt    = br_target;
          br_pend_d = 1'b0;
        end else if (br_pend_q) begin
          pc_load   = 1'b1;
          pc_sel    = PC_TGT;
          pc_tgt    = br_addr_q;
          br_pend_d = 1'b0;
        end
        if (en && !stall) begin
          state_d = S_REQ;
        end
      end
      S_REQ: begin
        if (mem.mem_ack) begin
          inst_valid_d = 1'b1;
          pc_load      = 1'b1;
          if (br_valid) begin
            pc_sel = PC_TGT;
            pc_tgt = br_target;
          end else if (br_pend_q) begin
            pc_sel = PC_TGT;
            pc_tgt = br_addr_q;
          end else begin
            pc_sel = PC_STEP;
          end
          br_pend_d = 1'b0;
          wait_d    = '0;
          state_d   = (en && !stall) ? S_REQ : S_IDLE;
        end else begin
          // Latest branch wins while the fetch is outstanding.
          if (br_valid) begin
            br_pend_d = 1'b1;
            br_addr_d = br_target;
          end
          if (wait_q == WAIT_W'(MAX_WAIT - 1)) begin
            state_d = S_ERR;
            err_d   = 1'b1;
            wait_d  = '0;
          end else begin
            wait_d = wait_q + WAIT_W'(1);
          end
        end
      end
      S_ERR: begin
        err_d = 1'b1;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    mem_req_d = (state_d == S_REQ);
    busy_d    = (state_d == S_REQ);
  end

  // State and registered outputs; reset overrides everything.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q      <= S_IDLE;
      wait_q       <= '0;
      br_pend_q    <= 1'b0;
      br_addr_q    <= '0;
      inst_valid_q <= 1'b0;
      err_q        <= 1'b0;
      mem_req_q    <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      wait_q       <= wait_d;
      br_pend_q    <= br_pend_d;
      br_addr_q    <= br_addr_d;
      inst_valid_q <= inst_valid_d;
      err_q        <= err_d;
      mem_req_q    <= mem_req_d;
      busy_q       <= busy_d;
    end
  end

  assign mem.mem_req  = mem_req_q;
  assign mem.mem_addr = pc_q;
  assign pc_out       = pc_q;
  assign inst_valid   = inst_valid_q;
  assign timeout_err  = err_q;
  assign busy         = busy_q;

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Directed self-checking bench for pc_fetch_ctrl.
module tb_pc_fetch_ctrl;

  logic        CLK;
  logic        RST;
  logic        en;
  logic        stall;
  logic        br_valid;
  logic [31:0] br_target;
  logic [31:0] pc_out;
  logic        inst_valid;
  logic        timeout_err;
  logic        busy;

  int n_checks;
  int n_fail;

  pc_fetch_ctrl_if #(.WIDTH(32)) mem_bus ();

  pc_fetch_ctrl dut (
    .CLK         (CLK),
    .RST         (RST),
    .en          (en),
    .stall       (stall),
    .br_valid    (br_valid),
    .br_target   (br_target),
    .mem         (mem_bus),
    .pc_out      (pc_out),
    .inst_valid  (inst_valid),
    .timeout_err (timeout_err),
    .busy        (busy)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Advance one rising edge and settle just after it.
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset();
    RST = 1'b1; en = 1'b0; stall = 1'b0; br_valid = 1'b0; br_target = '0;
    mem_bus.mem_ack = 1'b0;
    tick();
    tick();
    RST = 1'b0;
    n_checks++;
    if (pc_out !== 32'h0040_0000) begin n_fail++; $display("FAIL reset_pc: got %h expected %h", pc_out, 32'h0040_0000); end
    n_checks++;
    if (mem_bus.mem_addr !== 32'h0040_0000) begin n_fail++; $display("FAIL reset_addr: got %h expected %h", mem_bus.mem_addr, 32'h0040_0000); end
    n_checks++;
    if ({mem_bus.mem_req, inst_valid, timeout_err, busy} !== 4'b0000) begin
      n_fail++; $display("FAIL reset_flags: got %b expected 0000", {mem_bus.mem_req, inst_valid, timeout_err, busy});
    end
  endtask

  task automatic test_sequential();
    logic [31:0] exp_addr;
    exp_addr = 32'h0040_0000;
    en = 1'b1;
    tick();
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if ({mem_bus.mem_req, busy} !== 2'b11 || mem_bus.mem_addr !== exp_addr) begin
        n_fail++; $display("FAIL seq_req%0d: got req=%b addr=%h expected req=1 addr=%h", i, mem_bus.mem_req, mem_bus.mem_addr, exp_addr);
      end
      tick();
      n_checks++;
      if (inst_valid !== 1'b0 || mem_bus.mem_addr !== exp_addr || mem_bus.mem_req !== 1'b1) begin
        n_fail++; $display("FAIL seq_wait%0d: got iv=%b addr=%h expected iv=0 addr=%h", i, inst_valid, mem_bus.mem_addr, exp_addr);
      end
      mem_bus.mem_ack = 1'b1;
      tick();
      mem_bus.mem_ack = 1'b0;
      exp_addr = exp_addr + 32'd4;
      n_checks++;
      if (inst_valid !== 1'b1 || pc_out !== exp_addr) begin
        n_fail++; $display("FAIL seq_ack%0d: got iv=%b pc=%h expected iv=1 pc=%h", i, inst_valid, pc_out, exp_addr);
      end
    end
  endtask

  task automatic test_branch_on_ack();
    tick();
    mem_bus.mem_ack = 1'b1; br_valid = 1'b1; br_target = 32'h0040_0103;
    tick();
    mem_bus.mem_ack = 1'b0; br_valid = 1'b0;
    n_checks++;
    if (pc_out !== 32'h0040_0100 || mem_bus.mem_addr !== 32'h0040_0100) begin
      n_fail++; $display("FAIL branch_ack: got pc=%h addr=%h expected %h", pc_out, mem_bus.mem_addr, 32'h0040_0100);
    end
    n_checks++;
    if (inst_valid !== 1'b1 || mem_bus.mem_req !== 1'b1) begin
      n_fail++; $display("FAIL branch_ack_flags: got iv=%b req=%b expected 1 1", inst_valid, mem_bus.mem_req);
    end
  endtask

  task automatic test_branch_last_wins();
    br_valid = 1'b1; br_target = 32'h0000_0010;
    tick();
    br_valid = 1'b0;
    tick();
    br_valid = 1'b1; br_target = 32'h0000_0020;
    tick();
    br_valid = 1'b0;
    tick();
    n_checks++;
    if (pc_out !== 32'h0040_0100 || mem_bus.mem_req !== 1'b1) begin
      n_fail++; $display("FAIL branch_wait_stable: got pc=%h req=%b expected %h 1", pc_out, mem_bus.mem_req, 32'h0040_0100);
    end
    mem_bus.mem_ack = 1'b1;
    tick();
    mem_bus.mem_ack = 1'b0;
    n_checks++;
    if (pc_out !== 32'h0000_0020 || inst_valid !== 1'b1) begin
      n_fail++; $display("FAIL branch_last_wins: got pc=%h iv=%b expected %h 1", pc_out, inst_valid, 32'h0000_0020);
    end
  endtask

  task automatic test_stall();
    mem_bus.mem_ack = 1'b1; stall = 1'b1;
    tick();
    mem_bus.mem_ack = 1'b0;
    n_checks++;
    if (pc_out !== 32'h0000_0024 || mem_bus.mem_req !== 1'b0 || busy !== 1'b0 || inst_valid !== 1'b1) begin
      n_fail++; $display("FAIL stall_ack: got pc=%h req=%b busy=%b iv=%b expected 24 0 0 1", pc_out, mem_bus.mem_req, busy, inst_valid);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++;
      if (pc_out !== 32'h0000_0024 || mem_bus.mem_req !== 1'b0 || inst_valid !== 1'b0) begin
        n_fail++; $display("FAIL stall_hold%0d: got pc=%h req=%b iv=%b expected 24 0 0", i, pc_out, mem_bus.mem_req, inst_valid);
      end
    end
    stall = 1'b0;
    tick();
    n_checks++;
    if (mem_bus.mem_req !== 1'b1 || mem_bus.mem_addr !== 32'h0000_0024) begin
      n_fail++; $display("FAIL stall_resume: got req=%b addr=%h expected 1 %h", mem_bus.mem_req, mem_bus.mem_addr, 32'h0000_0024);
    end
  endtask

  task automatic test_timeout();
    for (int i = 0; i < 14; i++) tick();
    n_checks++;
    if (mem_bus.mem_req !== 1'b1 || timeout_err !== 1'b0) begin
      n_fail++; $display("FAIL timeout_early: got req=%b err=%b expected 1 0", mem_bus.mem_req, timeout_err);
    end
    tick();
    n_checks++;
    if (mem_bus.mem_req !== 1'b0 || timeout_err !== 1'b1 || busy !== 1'b0) begin
      n_fail++; $display("FAIL timeout_trip: got req=%b err=%b busy=%b expected 0 1 0", mem_bus.mem_req, timeout_err, busy);
    end
    mem_bus.mem_ack = 1'b1; br_valid = 1'b1; br_target = 32'h0000_0800;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++;
      if (timeout_err !== 1'b1 || mem_bus.mem_req !== 1'b0 || inst_valid !== 1'b0 || pc_out !== 32'h0000_0024) begin
        n_fail++; $display("FAIL timeout_stuck%0d: got err=%b req=%b iv=%b pc=%h expected 1 0 0 24", i, timeout_err, mem_bus.mem_req, inst_valid, pc_out);
      end
    end
    mem_bus.mem_ack = 1'b0; br_valid = 1'b0; en = 1'b0;
    RST = 1'b1;
    tick();
    RST = 1'b0;
    n_checks++;
    if (pc_out !== 32'h0040_0000 || timeout_err !== 1'b0 || mem_bus.mem_req !== 1'b0) begin
      n_fail++; $display("FAIL timeout_recover: got pc=%h err=%b req=%b expected 00400000 0 0", pc_out, timeout_err, mem_bus.mem_req);
    end
  endtask

  task automatic test_reset_mid_req();
    en = 1'b1;
    tick();
    tick();
    n_checks++;
    if (mem_bus.mem_req !== 1'b1) begin n_fail++; $display("FAIL rst_req_setup: got req=%b expected 1", mem_bus.mem_req); end
    RST = 1'b1; mem_bus.mem_ack = 1'b1; en = 1'b0;
    tick();
    RST = 1'b0;
    n_checks++;
    if (mem_bus.mem_req !== 1'b0 || inst_valid !== 1'b0 || pc_out !== 32'h0040_0000) begin
      n_fail++; $display("FAIL rst_mid_req: got req=%b iv=%b pc=%h expected 0 0 00400000", mem_bus.mem_req, inst_valid, pc_out);
    end
    tick();
    mem_bus.mem_ack = 1'b0;
    n_checks++;
    if (inst_valid !== 1'b0 || pc_out !== 32'h0040_0000) begin
      n_fail++; $display("FAIL ack_in_idle: got iv=%b pc=%h expected 0 00400000", inst_valid, pc_out);
    end
  endtask

  task automatic test_wrap();
    br_valid = 1'b1; br_target = 32'hFFFF_FFFC; en = 1'b1;
    tick();
    br_valid = 1'b0;
    n_checks++;
    if (mem_bus.mem_req !== 1'b1 || mem_bus.mem_addr !== 32'hFFFF_FFFC) begin
      n_fail++; $display("FAIL wrap_setup: got req=%b addr=%h expected 1 fffffffc", mem_bus.mem_req, mem_bus.mem_addr);
    end
    mem_bus.mem_ack = 1'b1; en = 1'b0;
    tick();
    mem_bus.mem_ack = 1'b0;
    n_checks++;
    if (pc_out !== 32'h0000_0000 || inst_valid !== 1'b1 || mem_bus.mem_req !== 1'b0) begin
      n_fail++; $display("FAIL wrap: got pc=%h iv=%b req=%b expected 00000000 1 0", pc_out, inst_valid, mem_bus.mem_req);
    end
  endtask

  task automatic test_back_to_back();
    en = 1'b1;
    tick();
    mem_bus.mem_ack = 1'b1;
    tick();
    n_checks++;
    if (pc_out !== 32'h0000_0004 || inst_valid !== 1'b1 || mem_bus.mem_req !== 1'b1) begin
      n_fail++; $display("FAIL b2b_first: got pc=%h iv=%b req=%b expected 4 1 1", pc_out, inst_valid, mem_bus.mem_req);
    end
    tick();
    mem_bus.mem_ack = 1'b0;
    n_checks++;
    if (pc_out !== 32'h0000_0008 || inst_valid !== 1'b1) begin
      n_fail++; $display("FAIL b2b_second: got pc=%h iv=%b expected 8 1", pc_out, inst_valid);
    end
    tick();
    n_checks++;
    if (inst_valid !== 1'b0 || pc_out !== 32'h0000_0008) begin
      n_fail++; $display("FAIL b2b_idle_pulse: got iv=%b pc=%h expected 0 8", inst_valid, pc_out);
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset();
    test_sequential();
    test_branch_on_ack();
    test_branch_last_wins();
    test_stall();
    test_timeout();
    test_reset_mid_req();
    test_wrap();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
